rename_regfile: RTL and testbench

RENAME_REGFILE -- requirements
Module: rename_regfile

---
 rtl/rename_regfile_pkg.sv | 33 +++
 rtl/rename_regfile_lookup.sv | 50 +++++
 rtl/rename_regfile.sv | 131 +++++++++++++
 tb/tb_rename_regfile.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_regfile_pkg.sv
// Shared rename/ROB definitions: sizes, tag encoding and ROB entry layout.
// Imported by the register alias table and its lookup ports.
package rename_regfile_pkg;

    localparam int REG_SZ_LOG = 4;
    localparam int ROB_SZ_LOG = 4;
    localparam int REG_SZ     = 2 ** (REG_SZ_LOG + 1);
    localparam int ROB_SZ     = 2 ** (ROB_SZ_LOG + 1);

    typedef logic [REG_SZ_LOG:0] reg_idx_t;
    typedef logic [ROB_SZ_LOG:0] rob_tag_t;
    typedef logic [31:0]         word_t;

    // Tag 0 is never allocated by the ROB, so it doubles as "no producer".
    localparam rob_tag_t TAG_NONE = '0;

    typedef enum logic [1:0] {
        ROB_ST_EMPTY,
        ROB_ST_ISSUED,
        ROB_ST_DONE
    } rob_state_e;

    typedef struct packed {
        rob_state_e state;
        reg_idx_t   rd;
        word_t      val;
    } rob_entry_t;

    function automatic logic tag_is_valid(input rob_tag_t t);
        return t != TAG_NONE;
    endfunction

endpackage

// File: rtl/rename_regfile_lookup.sv
// One source-operand read port of the register alias table.
// Resolves an operand from the table, a same-cycle commit, or the ROB.
module rename_lookup #(
    parameter int IW = 5,
    parameter int TW = 5
) (
    input  logic [IW-1:0] idx_i,
    input  logic          busy_i,
    input  logic [TW-1:0] tag_i,
    input  logic [31:0]   value_i,
    input  logic          cmt_en_i,
    input  logic [IW-1:0] cmt_rd_i,
    input  logic [TW-1:0] cmt_tag_i,
    input  logic [31:0]   cmt_val_i,
    input  logic          rob_ready_i,
    input  logic [31:0]   rob_val_i,
    output logic [TW-1:0] rob_tag_o,
    output logic          ready_o,
    output logic [31:0]   val_o,
    output logic [TW-1:0] tag_o
);

    logic cmt_hit;

    assign cmt_hit = cmt_en_i && (cmt_rd_i == idx_i) && (cmt_tag_i == tag_i);

    always_comb begin
        ready_o   = 1'b1;
        val_o     = '0;
        tag_o     = '0;
        rob_tag_o = '0;
        if (idx_i != '0) begin
            if (!busy_i) begin
                val_o = value_i;
            end else begin
                rob_tag_o = tag_i;
                // A commit retiring the producer this cycle beats the ROB copy.
                if (cmt_hit) begin
                    val_o = cmt_val_i;
                end else if (rob_ready_i) begin
                    val_o = rob_val_i;
                end else begin
                    ready_o = 1'b0;
                    tag_o   = tag_i;
                end
            end
        end
    end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with rename (busy/tag) state per register.
// Issue marks a register as pending on a ROB tag; commit retires it.
module rename_regfile
    import rename_regfile_pkg::*;
#(
    parameter int REG_SZ_LOG = rename_regfile_pkg::REG_SZ_LOG,
    parameter int ROB_SZ_LOG = rename_regfile_pkg::ROB_SZ_LOG
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush,
    input  logic                  iss_en,
    input  logic [REG_SZ_LOG:0]   iss_rd,
    input  logic [ROB_SZ_LOG:0]   iss_tag,
    input  logic                  cmt_en,
    input  logic [REG_SZ_LOG:0]   cmt_rd,
    input  logic [31:0]           cmt_val,
    input  logic [ROB_SZ_LOG:0]   cmt_tag,
    input  logic [REG_SZ_LOG:0]   rs1_idx,
    input  logic [REG_SZ_LOG:0]   rs2_idx,
    output logic [ROB_SZ_LOG:0]   rob_rs1_tag,
    output logic [ROB_SZ_LOG:0]   rob_rs2_tag,
    input  logic                  rob_rs1_ready,
    input  logic                  rob_rs2_ready,
    input  logic [31:0]           rob_rs1_val,
    input  logic [31:0]           rob_rs2_val,
    output logic                  rs1_ready,
    output logic                  rs2_ready,
    output logic [31:0]           rs1_val,
    output logic [31:0]           rs2_val,
    output logic [ROB_SZ_LOG:0]   rs1_tag,
    output logic [ROB_SZ_LOG:0]   rs2_tag
);

    localparam int NREG = 2 ** (REG_SZ_LOG + 1);
    localparam int IW   = REG_SZ_LOG + 1;
    localparam int TW   = ROB_SZ_LOG + 1;

    logic [31:0]   value_q [NREG];
    logic [31:0]   value_d [NREG];
    logic [TW-1:0] tag_q   [NREG];
    logic [TW-1:0] tag_d   [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    logic iss_live;
    logic cmt_live;

    assign iss_live = iss_en && (iss_rd != '0) && !flush;
    assign cmt_live = cmt_en && (cmt_rd != '0);

    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        busy_d  = busy_q;
        if (rdy) begin
            if (cmt_live) begin
                value_d[cmt_rd] = cmt_val;
                // A newer issue to the same register keeps it pending.
                if ((tag_q[cmt_rd] == cmt_tag) &&
                    !(iss_live && (iss_rd == cmt_rd))) begin
                    busy_d[cmt_rd] = 1'b0;
                end
            end
            if (flush) begin
                busy_d = '0;
                for (int i = 0; i < NREG; i++) begin
                    tag_d[i] = '0;
                end
            end else if (iss_live) begin
                busy_d[iss_rd] = 1'b1;
                tag_d[iss_rd]  = iss_tag;
            end
        end
        value_d[0] = '0;
        busy_d[0]  = 1'b0;
        tag_d[0]   = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int i = 0; i < NREG; i++) begin
                value_q[i] <= value_d[i];
                tag_q[i]   <= tag_d[i];
            end
        end
    end

    rename_lookup #(.IW(IW), .TW(TW)) u_rs1 (
        .idx_i       (rs1_idx),
        .busy_i      (busy_q[rs1_idx]),
        .tag_i       (tag_q[rs1_idx]),
        .value_i     (value_q[rs1_idx]),
        .cmt_en_i    (cmt_en),
        .cmt_rd_i    (cmt_rd),
        .cmt_tag_i   (cmt_tag),
        .cmt_val_i   (cmt_val),
        .rob_ready_i (rob_rs1_ready),
        .rob_val_i   (rob_rs1_val),
        .rob_tag_o   (rob_rs1_tag),
        .ready_o     (rs1_ready),
        .val_o       (rs1_val),
        .tag_o       (rs1_tag)
    );

    rename_lookup #(.IW(IW), .TW(TW)) u_rs2 (
        .idx_i       (rs2_idx),
        .busy_i      (busy_q[rs2_idx]),
        .tag_i       (tag_q[rs2_idx]),
        .value_i     (value_q[rs2_idx]),
        .cmt_en_i    (cmt_en),
        .cmt_rd_i    (cmt_rd),
        .cmt_tag_i   (cmt_tag),
        .cmt_val_i   (cmt_val),
        .rob_ready_i (rob_rs2_ready),
        .rob_val_i   (rob_rs2_val),
        .rob_tag_o   (rob_rs2_tag),
        .ready_o     (rs2_ready),
        .val_o       (rs2_val),
        .tag_o       (rs2_tag)
    );

endmodule

// File: tb/tb_rename_regfile.sv
// Scoreboard bench for rename_regfile: expectations queued with stimulus,
// drained against the combinational lookup outputs before the next edge.
module tb_rename_regfile;

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic        iss_en, cmt_en;
    logic [4:0]  iss_rd, cmt_rd, rs1_idx, rs2_idx;
    logic [4:0]  iss_tag, cmt_tag;
    logic [31:0] cmt_val, rob_rs1_val, rob_rs2_val;
    logic        rob_rs1_ready, rob_rs2_ready;
    logic [4:0]  rob_rs1_tag, rob_rs2_tag, rs1_tag, rs2_tag;
    logic        rs1_ready, rs2_ready;
    logic [31:0] rs1_val, rs2_val;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    localparam int R1 = 0, V1 = 1, T1 = 2, Q1 = 3;
    localparam int R2 = 4, V2 = 5, T2 = 6, Q2 = 7;

    always #5 clk = ~clk;

    rename_regfile dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .flush         (flush),
        .iss_en        (iss_en),
        .iss_rd        (iss_rd),
        .iss_tag       (iss_tag),
        .cmt_en        (cmt_en),
        .cmt_rd        (cmt_rd),
        .cmt_val       (cmt_val),
        .cmt_tag       (cmt_tag),
        .rs1_idx       (rs1_idx),
        .rs2_idx       (rs2_idx),
        .rob_rs1_tag   (rob_rs1_tag),
        .rob_rs2_tag   (rob_rs2_tag),
        .rob_rs1_ready (rob_rs1_ready),
        .rob_rs2_ready (rob_rs2_ready),
        .rob_rs1_val   (rob_rs1_val),
        .rob_rs2_val   (rob_rs2_val),
        .rs1_ready     (rs1_ready),
        .rs2_ready     (rs2_ready),
        .rs1_val       (rs1_val),
        .rs2_val       (rs2_val),
        .rs1_tag       (rs1_tag),
        .rs2_tag       (rs2_tag)
    );

    task automatic check(input string name, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            R1: return {31'd0, rs1_ready};
            V1: return rs1_val;
            T1: return {27'd0, rs1_tag};
            Q1: return {27'd0, rob_rs1_tag};
            R2: return {31'd0, rs2_ready};
            V2: return rs2_val;
            T2: return {27'd0, rs2_tag};
            default: return {27'd0, rob_rs2_tag};
        endcase
    endfunction

    task automatic push_exp(input string name, input int sel,
                            input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #3;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, pick(e.sel), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 1'b0; iss_en = 1'b0; cmt_en = 1'b0;
        iss_rd = '0; iss_tag = '0; cmt_rd = '0; cmt_tag = '0; cmt_val = '0;
        rob_rs1_ready = 1'b0; rob_rs2_ready = 1'b0;
        rob_rs1_val = '0; rob_rs2_val = '0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [4:0] tg);
        iss_en = 1'b1; iss_rd = rd; iss_tag = tg;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [4:0] tg,
                          input logic [31:0] v);
        cmt_en = 1'b1; cmt_rd = rd; cmt_tag = tg; cmt_val = v;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; rs1_idx = '0; rs2_idx = '0;
        idle();
        tick(); tick();
        rst = 1'b0;

        // pre-load x7 so that reset clearing a value is observable
        commit(5'd7, 5'd0, 32'h77);
        tick(); idle();
        rs1_idx = 5'd7;
        push_exp("preload_val", V1, 32'h77);
        drain();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rs1_idx = 5'd7; rs2_idx = 5'd5;
        push_exp("rst_x7_val", V1, 32'h0);
        push_exp("rst_x7_rdy", R1, 32'h1);
        push_exp("rst_x5_rdy", R2, 32'h1);
        push_exp("rst_x5_val", V2, 32'h0);
        push_exp("rst_x5_robtag", Q2, 32'h0);
        drain();

        // issue x5 tag 3; same-cycle read sees pre-issue mapping
        issue(5'd5, 5'd3);
        rs1_idx = 5'd5;
        push_exp("iss_same_rdy", R1, 32'h1);
        push_exp("iss_same_robtag", Q1, 32'h0);
        drain();
        tick(); idle();
        push_exp("busy_rdy", R1, 32'h0);
        push_exp("busy_tag", T1, 32'h3);
        push_exp("busy_robtag", Q1, 32'h3);
        drain();
        rob_rs1_ready = 1'b1; rob_rs1_val = 32'h55;
        push_exp("rob_rdy", R1, 32'h1);
        push_exp("rob_val", V1, 32'h55);
        drain();

        // commit bypass then retirement
        idle();
        commit(5'd5, 5'd3, 32'hAB);
        push_exp("byp_rdy", R1, 32'h1);
        push_exp("byp_val", V1, 32'hAB);
        drain();
        tick(); idle();
        push_exp("cmt_rdy", R1, 32'h1);
        push_exp("cmt_val", V1, 32'hAB);
        push_exp("cmt_robtag", Q1, 32'h0);
        drain();

        // stale commit after reissue keeps the newer mapping
        issue(5'd5, 5'd3); tick();
        issue(5'd5, 5'd7); tick(); idle();
        commit(5'd5, 5'd3, 32'h11);
        rs2_idx = 5'd5;
        push_exp("stale_byp_rdy", R2, 32'h0);
        push_exp("stale_byp_tag", T2, 32'h7);
        drain();
        tick(); idle();
        push_exp("stale_rdy", R1, 32'h0);
        push_exp("stale_tag", T1, 32'h7);
        drain();

        // issue and commit to x6 in the same cycle: issue wins busy/tag
        issue(5'd6, 5'd2); tick(); idle();
        issue(5'd6, 5'd4);
        commit(5'd6, 5'd2, 32'h22);
        tick(); idle();
        rs2_idx = 5'd6;
        push_exp("race_rdy", R2, 32'h0);
        push_exp("race_tag", T2, 32'h4);
        drain();

        // rdy low: issue/commit ignored
        rdy = 1'b0;
        issue(5'd12, 5'd6);
        commit(5'd13, 5'd0, 32'hDEAD);
        tick(); idle();
        rdy = 1'b1;
        rs1_idx = 5'd12; rs2_idx = 5'd13;
        push_exp("hold_iss_rdy", R1, 32'h1);
        push_exp("hold_cmt_val", V2, 32'h0);
        drain();

        // x0 writes ignored
        issue(5'd0, 5'd9);
        commit(5'd0, 5'd0, 32'hFF);
        tick(); idle();
        rs1_idx = 5'd0;
        push_exp("x0_rdy", R1, 32'h1);
        push_exp("x0_val", V1, 32'h0);
        push_exp("x0_robtag", Q1, 32'h0);
        drain();

        // make x1..x31 busy, then flush with concurrent issue and commit
        for (int i = 1; i < 32; i++) begin
            issue(i[4:0], i[4:0]);
            tick();
        end
        idle();
        rs1_idx = 5'd20;
        push_exp("all_busy_rdy", R1, 32'h0);
        push_exp("all_busy_tag", T1, 32'd20);
        drain();
        flush = 1'b1;
        issue(5'd9, 5'd5);
        commit(5'd10, 5'd0, 32'h1010);
        tick(); idle();
        rs1_idx = 5'd9; rs2_idx = 5'd10;
        push_exp("fl_x9_rdy", R1, 32'h1);
        push_exp("fl_x9_robtag", Q1, 32'h0);
        push_exp("fl_cmt_val", V2, 32'h1010);
        drain();
        rs1_idx = 5'd5; rs2_idx = 5'd6;
        push_exp("fl_x5_val", V1, 32'h11);
        push_exp("fl_x6_val", V2, 32'h22);
        drain();
        for (int i = 1; i < 32; i++) begin
            rs1_idx = i[4:0];
            push_exp($sformatf("fl_rdy_x%0d", i), R1, 32'h1);
            push_exp($sformatf("fl_robtag_x%0d", i), Q1, 32'h0);
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
